// File: rtl/apb_cn_port.sv
// Completer-node port: round-robin arbitration across requester nodes for one APB completer.
// The completer-side APB sequence includes a wait-state timeout so a hung completer cannot lock the node.
module apb_cn_port #(
  parameter int NUM_RN     = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_RN-1:0]              rn_valid,
  input  logic [NUM_RN*ADDR_WIDTH-1:0]   rn_paddr,
  input  logic [NUM_RN-1:0]              rn_pwrite,
  input  logic [NUM_RN*DATA_WIDTH-1:0]   rn_pwdata,
  output logic [NUM_RN-1:0]              cn_ready,
  output logic [NUM_RN-1:0]              rn_pready,
  output logic [DATA_WIDTH-1:0]          rn_prdata,
  output logic                           rn_pslverr,
  output logic                           m_psel,
  output logic                           m_penable,
  output logic [ADDR_WIDTH-1:0]          m_paddr,
  output logic                           m_pwrite,
  output logic [DATA_WIDTH-1:0]          m_pwdata,
  input  logic                           m_pready,
  input  logic [DATA_WIDTH-1:0]          m_prdata,
  input  logic                           m_pslverr
);

  localparam int IDX_W = (NUM_RN > 1) ? $clog2(NUM_RN) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, gnt_q, arb_idx;
  logic                    arb_hit;
  logic [CNT_W-1:0]        cnt_q;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic                    pwrite_q;
  logic [DATA_WIDTH-1:0]   pwdata_q, rdata_q;
  logic                    err_q;
  logic                    timeout_hit;
  logic [NUM_RN-1:0]       gnt_oh;
  logic [2*NUM_RN-1:0]     vld_dbl, vld_shift;
  logic [NUM_RN-1:0]       vld_rot;

  logic [ADDR_WIDTH-1:0]   addr_a  [NUM_RN];
  logic [DATA_WIDTH-1:0]   wdata_a [NUM_RN];

  for (genvar i = 0; i < NUM_RN; i++) begin : g_unpack
    assign addr_a[i]  = rn_paddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[i] = rn_pwdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Rotate valids so bit 0 is the requester just after the last winner.
  assign vld_dbl   = {rn_valid, rn_valid};
  assign vld_shift = vld_dbl >> (int'(ptr_q) + 1);
  assign vld_rot   = vld_shift[NUM_RN-1:0];

  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    for (int i = NUM_RN - 1; i >= 0; i--) begin
      if (vld_rot[IDX_W'(i)]) begin
        arb_hit = 1'b1;
        arb_idx = IDX_W'((int'(ptr_q) + 1 + i) % NUM_RN);
      end
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign gnt_oh      = NUM_RN'(1) << gnt_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_hit) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (m_pready || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= IDX_W'(NUM_RN - 1);
      gnt_q    <= '0;
      cnt_q    <= '0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (arb_hit) begin
          gnt_q    <= arb_idx;
          ptr_q    <= arb_idx;
          paddr_q  <= addr_a[arb_idx];
          pwrite_q <= rn_pwrite[arb_idx];
          pwdata_q <= wdata_a[arb_idx];
        end
        SETUP: cnt_q <= '0;
        // A ready arriving on the timeout cycle takes priority over the synthetic error.
        ACCESS: begin
          if (m_pready) begin
            rdata_q <= m_prdata;
            err_q   <= m_pslverr;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_psel     = (state_q == SETUP) || (state_q == ACCESS);
  assign m_penable  = (state_q == ACCESS);
  assign m_paddr    = paddr_q;
  assign m_pwrite   = pwrite_q;
  assign m_pwdata   = pwdata_q;
  assign cn_ready   = m_psel ? gnt_oh : '0;
  assign rn_pready  = (state_q == RESP) ? gnt_oh : '0;
  assign rn_prdata  = (state_q == RESP) ? rdata_q : '0;
  assign rn_pslverr = (state_q == RESP) && err_q;

endmodule

// File: tb/tb_apb_cn_port.sv
// Bench for apb_cn_port: directed requests with a scoreboard of expected completions
// and a small APB completer model with programmable wait states.
module tb_apb_cn_port;

  localparam int NUM_RN = 2;
  localparam int AW     = 32;
  localparam int DW     = 32;

  logic                  clk, rst_n;
  logic [NUM_RN-1:0]     rn_valid, rn_pwrite, cn_ready, rn_pready;
  logic [NUM_RN*AW-1:0]  rn_paddr;
  logic [NUM_RN*DW-1:0]  rn_pwdata;
  logic [DW-1:0]         rn_prdata, m_pwdata, m_prdata;
  logic                  rn_pslverr, m_psel, m_penable, m_pwrite, m_pready, m_pslverr;
  logic [AW-1:0]         m_paddr;

  apb_cn_port #(.NUM_RN(NUM_RN), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .rn_valid(rn_valid), .rn_paddr(rn_paddr), .rn_pwrite(rn_pwrite), .rn_pwdata(rn_pwdata),
    .cn_ready(cn_ready), .rn_pready(rn_pready), .rn_prdata(rn_prdata), .rn_pslverr(rn_pslverr),
    .m_psel(m_psel), .m_penable(m_penable), .m_paddr(m_paddr), .m_pwrite(m_pwrite),
    .m_pwdata(m_pwdata), .m_pready(m_pready), .m_prdata(m_prdata), .m_pslverr(m_pslverr)
  );

  typedef struct {
    logic [NUM_RN-1:0] gnt;
    logic [AW-1:0]     addr;
    logic              wr;
    logic [DW-1:0]     wdata;
    logic [DW-1:0]     rdata;
    logic              err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Completer model knobs
  int   wait_n = 0;
  bit   stuck  = 0;
  int   acc    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Completer: holds m_pready low for wait_n ACCESS cycles, or forever when stuck.
  initial begin
    m_pready = 1'b0;
    forever begin
      @(negedge clk);
      if (m_psel && m_penable) begin
        m_pready = !stuck && (acc == wait_n);
        acc++;
      end else begin
        m_pready = 1'b0;
        acc = 0;
      end
    end
  end

  // Monitor: checks the transfer in flight and pops the expected completion.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (cn_ready != '0) chk("cn_ready_onehot", 64'($countones(cn_ready)), 64'd1);
      if (m_psel) begin
        if (exp_q.size() == 0) chk("unexpected_psel", 64'd1, 64'd0);
        else begin
          chk("cn_ready", 64'(cn_ready), 64'(exp_q[0].gnt));
          chk("m_paddr", 64'(m_paddr), 64'(exp_q[0].addr));
          chk("m_pwrite", 64'(m_pwrite), 64'(exp_q[0].wr));
          chk("m_pwdata", 64'(m_pwdata), 64'(exp_q[0].wdata));
        end
      end
      if (rn_pready != '0) begin
        if (exp_q.size() == 0) chk("unexpected_pready", 64'(rn_pready), 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("rn_pready", 64'(rn_pready), 64'(e.gnt));
          chk("rn_prdata", 64'(rn_prdata), 64'(e.rdata));
          chk("rn_pslverr", 64'(rn_pslverr), 64'(e.err));
          chk("psel_in_resp", 64'({m_psel, m_penable, cn_ready}), 64'd0);
        end
      end else begin
        chk("resp_idle_zero", 64'({rn_prdata, rn_pslverr}), 64'd0);
      end
    end
  end

  task automatic push(input int idx, input logic [AW-1:0] addr, input logic wr,
                      input logic [DW-1:0] wdata, input logic [DW-1:0] rdata, input logic err);
    exp_t e;
    e.gnt = NUM_RN'(1) << idx;
    e.addr = addr; e.wr = wr; e.wdata = wdata; e.rdata = rdata; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic drive_rn(input int idx, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data);
    rn_valid[idx] = 1'b1;
    rn_pwrite[idx] = wr;
    rn_paddr[idx*AW +: AW] = addr;
    rn_pwdata[idx*DW +: DW] = data;
  endtask

  // One request from requester idx; withdrawn in the first ACCESS cycle, where
  // `raise` may assert other requesters. lat = cycles from request to rn_pready.
  task automatic run_one(input int idx, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [DW-1:0] rdat, input logic err,
                         input int wn, input bit stk, input logic [NUM_RN-1:0] raise,
                         input int lat);
    int k;
    bit done;
    @(negedge clk);
    drive_rn(idx, wr, addr, data);
    wait_n = wn;
    stuck = stk;
    m_prdata = stk ? 32'h1234_5678 : rdat;
    m_pslverr = stk ? 1'b0 : err;
    push(idx, addr, wr, data, stk ? 32'h0 : rdat, stk ? 1'b1 : err);
    k = 0;
    done = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
      if (k == 1) chk("setup_phase", 64'({m_psel, m_penable}), 64'b10);
      if (k == 2) begin
        chk("access_phase", 64'({m_psel, m_penable}), 64'b11);
        rn_valid[idx] = 1'b0;
        rn_valid = rn_valid | raise;
      end
      if (rn_pready != '0) done = 1;
    end
    chk("latency", 64'(k), 64'(lat));
  endtask

  initial begin
    int n, cyc;
    rst_n = 1'b0;
    rn_valid = '0; rn_pwrite = '0; rn_paddr = '0; rn_pwdata = '0;
    m_prdata = '0; m_pslverr = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 64'({cn_ready, rn_pready, rn_pslverr, m_psel, m_penable, m_pwrite}), 64'd0);
    chk("reset_data", 64'({rn_prdata, m_paddr}), 64'd0);
    chk("reset_wdata", 64'(m_pwdata), 64'd0);
    rst_n = 1'b1;

    run_one(0, 1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 32'h0, 1'b0, 0, 0, 2'b00, 3);
    run_one(0, 1'b0, 32'h0000_0020, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 0, 2'b00, 6);
    run_one(1, 1'b0, 32'h0000_0030, 32'h0, 32'h0, 1'b0, 0, 1, 2'b00, 18);
    run_one(0, 1'b1, 32'h0000_0040, 32'h1111_2222, 32'hCAFE_F00D, 1'b1, 0, 0, 2'b00, 3);
    run_one(1, 1'b0, 32'h0000_0050, 32'h0, 32'h0BAD_CAFE, 1'b0, 15, 0, 2'b00, 18);

    // Reset in the middle of a hung ACCESS phase
    @(negedge clk);
    drive_rn(1, 1'b0, 32'h0000_0090, 32'h0);
    stuck = 1;
    push(1, 32'h0000_0090, 1'b0, 32'h0, 32'h0, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_mid_ctrl", 64'({cn_ready, rn_pready, rn_pslverr, m_psel, m_penable, m_pwrite}), 64'd0);
    chk("reset_mid_data", 64'({rn_prdata, m_paddr}), 64'd0);
    exp_q.delete();
    stuck = 0;
    wait_n = 0;
    m_prdata = 32'h0000_0055;
    m_pslverr = 1'b0;
    drive_rn(0, 1'b1, 32'h0000_0100, 32'h0000_AAAA);
    drive_rn(1, 1'b1, 32'h0000_0200, 32'h0000_BBBB);
    push(0, 32'h0000_0100, 1'b1, 32'h0000_AAAA, 32'h0000_0055, 1'b0);
    push(1, 32'h0000_0200, 1'b1, 32'h0000_BBBB, 32'h0000_0055, 1'b0);
    push(0, 32'h0000_0100, 1'b1, 32'h0000_AAAA, 32'h0000_0055, 1'b0);
    push(1, 32'h0000_0200, 1'b1, 32'h0000_BBBB, 32'h0000_0055, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Both requesters held valid: grants alternate with one IDLE cycle between
    n = 0;
    cyc = 0;
    while (n < 4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (rn_pready != '0) begin
        n++;
        if (n == 4) rn_valid = '0;
        @(negedge clk);
        cyc++;
        chk("idle_gap", 64'({m_psel, cn_ready}), 64'd0);
      end
    end
    chk("fair_count", 64'(n), 64'd4);
    chk("fair_cycles", 64'(cyc), 64'd16);

    // Requester 1 withdraws mid-ACCESS while 0 arrives; 1 still completes, then 0
    run_one(1, 1'b0, 32'h0000_0060, 32'h0, 32'h600D_0001, 1'b0, 2, 0, 2'b01, 5);
    run_one(0, 1'b0, 32'h0000_0070, 32'h0, 32'h7777_0000, 1'b0, 0, 0, 2'b00, 3);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
